// File: rtl/fifo_set_assoc_cache_if.sv
// Request/response bundle between the MEM stage, the data cache and the backing main memory.
// The master side is the pipeline plus the memory; the slave side is the cache itself.
interface fifo_set_assoc_cache_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 8
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

  logic [31:0]                          addr;
  logic                                 rd_req;
  logic                                 wr_req;
  logic [31:0]                          wr_data;
  logic [31:0]                          rd_data;
  logic                                 miss;
  logic                                 mem_rd_req;
  logic                                 mem_wr_req;
  logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr;
  logic [32*LINE_SIZE-1:0]              mem_wr_line;
  logic [32*LINE_SIZE-1:0]              mem_rd_line;
  logic                                 mem_gnt;

  modport master (
    output addr, rd_req, wr_req, wr_data, mem_rd_line, mem_gnt,
    input  rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_line
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data, mem_rd_line, mem_gnt,
    output rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_line
  );
endinterface

// File: rtl/fifo_set_assoc_cache.sv
// Set-associative write-back / write-allocate data cache with per-set FIFO replacement,
// placed at the MEM/WB boundary; misses stall the pipeline while a line is swapped.
module fifo_set_assoc_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 8,
  parameter int WAY_CNT       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_set_assoc_cache_if.slave  bus
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int SET_SIZE  = 1 << SET_ADDR_LEN;
  localparam int WAY_W     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam int LINE_W    = 32 * LINE_SIZE;
  localparam int ADDR_HI   = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
  state_t state;

  logic [31:0]             data_mem  [SET_SIZE][WAY_CNT][LINE_SIZE];
  logic [TAG_ADDR_LEN-1:0] tag_mem   [SET_SIZE][WAY_CNT];
  logic                    valid_mem [SET_SIZE][WAY_CNT];
  logic                    dirty_mem [SET_SIZE][WAY_CNT];
  logic [WAY_W-1:0]        fifo_ptr  [SET_SIZE];

  logic [LINE_ADDR_LEN-1:0] req_word;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic                     req_any;
  logic                     hit;
  logic [WAY_W-1:0]         hit_way;
  logic [WAY_W-1:0]         victim_way;
  logic [LINE_W-1:0]        victim_line;
  logic                     unused_addr_bits;

  // Miss context captured when leaving IDLE, so a dropped request still completes its fill
  logic [TAG_ADDR_LEN-1:0]  miss_tag_p1;
  logic [SET_ADDR_LEN-1:0]  miss_set_p1;
  logic [WAY_W-1:0]         victim_p1;
  logic [LINE_W-1:0]        fill_line_p1;

  function automatic logic [WAY_W-1:0] ptr_next(input logic [WAY_W-1:0] p);
    return (p == WAY_W'(WAY_CNT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_word = bus.addr[2 +: LINE_ADDR_LEN];
  assign req_set  = bus.addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign req_tag  = bus.addr[2 + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
  assign req_any  = bus.rd_req | bus.wr_req;
  assign unused_addr_bits = ^{bus.addr[31:ADDR_HI], bus.addr[1:0]};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid_mem[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = fifo_ptr[req_set];

  always_comb begin
    victim_line = '0;
    for (int i = 0; i < LINE_SIZE; i++)
      victim_line[32*i +: 32] = data_mem[req_set][victim_way][i];
  end

  assign bus.miss = req_any & ((state != IDLE) | ~hit);

  // Control: FSM, line status bits, replacement pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.rd_data     <= '0;
      bus.mem_rd_req  <= 1'b0;
      bus.mem_wr_req  <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_line <= '0;
      for (int s = 0; s < SET_SIZE; s++) begin
        fifo_ptr[s] <= '0;
        for (int w = 0; w < WAY_CNT; w++) begin
          valid_mem[s][w] <= 1'b0;
          dirty_mem[s][w] <= 1'b0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_any && hit) begin
            if (bus.wr_req) dirty_mem[req_set][hit_way] <= 1'b1;
            else            bus.rd_data <= data_mem[req_set][hit_way][req_word];
          end else if (req_any) begin
            if (valid_mem[req_set][victim_way] && dirty_mem[req_set][victim_way]) begin
              state           <= SWAP_OUT;
              bus.mem_wr_req  <= 1'b1;
              bus.mem_addr    <= {tag_mem[req_set][victim_way], req_set};
              bus.mem_wr_line <= victim_line;
            end else begin
              state          <= SWAP_IN;
              bus.mem_rd_req <= 1'b1;
              bus.mem_addr   <= {req_tag, req_set};
            end
          end
        end
        SWAP_OUT: begin
          if (bus.mem_gnt) begin
            state          <= SWAP_IN;
            bus.mem_wr_req <= 1'b0;
            bus.mem_rd_req <= 1'b1;
            bus.mem_addr   <= {miss_tag_p1, miss_set_p1};
          end
        end
        SWAP_IN: begin
          if (bus.mem_gnt) begin
            state          <= SWAP_IN_OK;
            bus.mem_rd_req <= 1'b0;
          end
        end
        SWAP_IN_OK: begin
          state                              <= IDLE;
          valid_mem[miss_set_p1][victim_p1]  <= 1'b1;
          dirty_mem[miss_set_p1][victim_p1]  <= 1'b0;
          fifo_ptr[miss_set_p1]              <= ptr_next(fifo_ptr[miss_set_p1]);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: line storage, tags and miss context carry no reset
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (req_any && hit && bus.wr_req)
          data_mem[req_set][hit_way][req_word] <= bus.wr_data;
        if (req_any && !hit) begin
          miss_tag_p1 <= req_tag;
          miss_set_p1 <= req_set;
          victim_p1   <= victim_way;
        end
      end
      SWAP_IN: begin
        if (bus.mem_gnt) fill_line_p1 <= bus.mem_rd_line;
      end
      SWAP_IN_OK: begin
        tag_mem[miss_set_p1][victim_p1] <= miss_tag_p1;
        for (int i = 0; i < LINE_SIZE; i++)
          data_mem[miss_set_p1][victim_p1][i] <= fill_line_p1[32*i +: 32];
      end
      default: ;
    endcase
  end
endmodule
